// File: rtl/sram_bus_arbiter.sv
// Two-master sram-like arbiter: merges inst/data ports onto one shared port with in-order tag FIFO.
// Optional round-robin priority when SRAM_ARB_RR_EN is defined (default: fixed DATA over INST).
module sram_bus_arbiter #(
   parameter int unsigned OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
   localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam logic        INST  = 1'b0;
   localparam logic        DATA  = 1'b1;

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
   logic [OUTSTANDING-1:0] tag_q;
   logic                   lock_q, owner_q;
   logic                   grant, pref, full, push, pop, head_tag;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef SRAM_ARB_RR_EN
   logic rr_q;
   assign pref = rr_q;
`else
   assign pref = DATA;
`endif

   always_comb begin
      full = (cnt_q == CNT_W'(OUTSTANDING));
      if (lock_q)                      grant = owner_q;
      else if (data_req && inst_req)   grant = pref;
      else                             grant = data_req ? DATA : INST;

      // Full blocks new requests even when a pop lands this cycle (no data_ok -> req path).
      mem_req   = (inst_req | data_req) & ~full & ~reset;
      mem_wr    = (grant == DATA) ? data_wr    : 1'b0;
      mem_size  = (grant == DATA) ? data_size  : 2'd2;
      mem_wstrb = (grant == DATA) ? data_wstrb : 4'd0;
      mem_addr  = (grant == DATA) ? data_addr  : inst_addr;
      mem_wdata = (grant == DATA) ? data_wdata : 32'd0;

      push     = mem_req & mem_addr_ok;
      pop      = mem_data_ok & (cnt_q != '0) & ~reset;
      head_tag = tag_q[rd_ptr_q];

      inst_addr_ok = push & (grant == INST);
      data_addr_ok = push & (grant == DATA);
      inst_data_ok = pop & (head_tag == INST);
      data_data_ok = pop & (head_tag == DATA);
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;

      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         tag_q    <= '0;
         lock_q   <= 1'b0;
         owner_q  <= DATA;
`ifdef SRAM_ARB_RR_EN
         rr_q     <= DATA;
`endif
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            tag_q[wr_ptr_q] <= grant;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         // A stalled request pins the grant until it is accepted.
         if (push) begin
            lock_q <= 1'b0;
         end else if (mem_req) begin
            lock_q  <= 1'b1;
            owner_q <= grant;
         end
`ifdef SRAM_ARB_RR_EN
         if (push) rr_q <= ~grant;
`endif
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter (OUTSTANDING=2), checks via immediate asserts.
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sram_bus_arbiter #(.OUTSTANDING(2)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   // A master whose stalled request was pending must not withdraw it.
   logic hold_chk = 1'b0, prev_i = 1'b0, prev_d = 1'b0;
   always @(posedge clk) begin
      if (hold_chk && !reset) begin
         assert ((!prev_i || inst_req) && (!prev_d || data_req)) else begin
            n_fail = n_fail + 1;
            $error("FAIL req_hold: inst_req=%0b data_req=%0b required held", inst_req, data_req);
         end
      end
      hold_chk <= !reset && mem_req && !mem_addr_ok;
      prev_i   <= inst_req;
      prev_d   <= data_req;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_d, prev_g;
      reset = 1'b1;
      inst_req = 1'b1; inst_addr = '0;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = '0;
      data_addr = '0; data_wdata = '0;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = '0;

      // 1: reset held with requests pending
      repeat (3) begin
         tick();
         chk("rst_outs", {27'd0, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
             32'd0);
      end
      inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      reset = 1'b0;
      tick();

      // 2: simultaneous requests, fixed priority, in-order responses
      inst_req = 1'b1; inst_addr = 32'h1c00_0000;
      data_req = 1'b1; data_addr = 32'h0000_1000;
      mem_addr_ok = 1'b1;
      #1;
      chk("t2_grant_d", {30'd0, inst_addr_ok, data_addr_ok}, 32'b01);
      chk("t2_addr_d", mem_addr, 32'h0000_1000);
      tick();
      data_req = 1'b0;
      #1;
      chk("t2_grant_i", {30'd0, inst_addr_ok, data_addr_ok}, 32'b10);
      chk("t2_addr_i", mem_addr, 32'h1c00_0000);
      chk("t2_ctl_i", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, 1'b0, 2'd2, 4'h0});
      tick();
      inst_req = 1'b0; mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_5555;
      #1;
      chk("t2_rsp1", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
      chk("t2_rdata1", data_rdata, 32'hAAAA_5555);
      tick();
      mem_rdata = 32'h1234_5678;
      #1;
      chk("t2_rsp2", {30'd0, inst_data_ok, data_data_ok}, 32'b10);
      chk("t2_rdata2", inst_rdata, 32'h1234_5678);
      tick();
      mem_data_ok = 1'b0;

      // 3: data request stalled, lock keeps it on the port while inst arrives
      data_req = 1'b1; data_addr = 32'h0000_2000; data_wr = 1'b1;
      data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
      #1;
      chk("t3_req", {31'd0, mem_req}, 32'd1);
      chk("t3_nack", {31'd0, data_addr_ok}, 32'd0);
      tick();
      inst_req = 1'b1; inst_addr = 32'h1c00_0004;
      #1;
      chk("t3_lock_addr1", mem_addr, 32'h0000_2000);
      chk("t3_inst_wait", {31'd0, inst_addr_ok}, 32'd0);
      tick();
      chk("t3_lock_addr2", mem_addr, 32'h0000_2000);
      tick();
      mem_addr_ok = 1'b1;
      #1;
      chk("t3_grant_d", {30'd0, inst_addr_ok, data_addr_ok}, 32'b01);
      chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t3_ctl_d", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, 1'b1, 2'd2, 4'hF});
      tick();
      data_req = 1'b0;
      #1;
      chk("t3_grant_i", {30'd0, inst_addr_ok, data_addr_ok}, 32'b10);
      tick();

      // 4: two outstanding -> full; a pop frees one slot after a bubble
      inst_req = 1'b0;
      data_req = 1'b1; data_addr = 32'h0000_3000; data_wr = 1'b0; data_wstrb = 4'h0;
      #1;
      chk("t4_full_req", {31'd0, mem_req}, 32'd0);
      chk("t4_full_ack", {31'd0, data_addr_ok}, 32'd0);
      tick();
      chk("t4_full_req2", {31'd0, mem_req}, 32'd0);
      mem_data_ok = 1'b1;
      #1;
      chk("t4_pop_d", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
      chk("t4_bubble", {31'd0, mem_req}, 32'd0);
      tick();
      mem_data_ok = 1'b0;
      #1;
      chk("t4_req_again", {30'd0, mem_req, data_addr_ok}, 32'b11);
      tick();
      data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      #1;
      chk("t4_pop_i", {30'd0, inst_data_ok, data_data_ok}, 32'b10);
      tick();
      chk("t4_pop_d2", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
      tick();
      mem_data_ok = 1'b0;

      // 3b: inst request stalled; data arriving later must not steal the port
      inst_req = 1'b1; inst_addr = 32'h1c00_0008;
      #1;
      chk("t3b_addr", mem_addr, 32'h1c00_0008);
      tick();
      data_req = 1'b1; data_addr = 32'h0000_4000;
      #1;
      chk("t3b_lock_addr", mem_addr, 32'h1c00_0008);
      chk("t3b_no_ack", {30'd0, inst_addr_ok, data_addr_ok}, 32'b00);
      tick();
      mem_addr_ok = 1'b1;
      #1;
      chk("t3b_grant_i", {30'd0, inst_addr_ok, data_addr_ok}, 32'b10);
      tick();
      inst_req = 1'b0;
      #1;
      chk("t3b_grant_d", {30'd0, inst_addr_ok, data_addr_ok}, 32'b01);
      tick();
      data_req = 1'b0; mem_addr_ok = 1'b0;

      // 5: drain, then spurious mem_data_ok with nothing outstanding
      mem_data_ok = 1'b1;
      #1;
      chk("t5_drain_i", {30'd0, inst_data_ok, data_data_ok}, 32'b10);
      tick();
      chk("t5_drain_d", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
      tick();
      chk("t5_spur1", {30'd0, inst_data_ok, data_data_ok}, 32'b00);
      tick();
      chk("t5_spur2", {30'd0, inst_data_ok, data_data_ok}, 32'b00);
      mem_data_ok = 1'b0;
      data_req = 1'b1; mem_addr_ok = 1'b1;
      tick();
      tick();
      chk("t5_cnt_full", {31'd0, mem_req}, 32'd0);

      // Reset mid-operation: outstanding entries dropped, late response ignored
      data_req = 1'b0; mem_addr_ok = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0; mem_data_ok = 1'b1;
      #1;
      chk("rst_mid_late", {30'd0, inst_data_ok, data_data_ok}, 32'b00);
      data_req = 1'b1; mem_addr_ok = 1'b1;
      #1;
      chk("rst_mid_req", {30'd0, mem_req, data_addr_ok}, 32'b11);
      tick();
      data_req = 1'b0; mem_addr_ok = 1'b0;
      #1;
      chk("rst_mid_rsp", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
      tick();
      mem_data_ok = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // 6: both masters requesting continuously with a response every cycle
      inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      prev_g = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
`ifdef SRAM_ARB_RR_EN
         exp_d = (k % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         chk($sformatf("t6_grant%0d", k), {30'd0, inst_addr_ok, data_addr_ok},
             exp_d ? 32'b01 : 32'b10);
         if (k == 0)
            chk("t6_rsp0", {30'd0, inst_data_ok, data_data_ok}, 32'b00);
         else
            chk($sformatf("t6_rsp%0d", k), {30'd0, inst_data_ok, data_data_ok},
                prev_g ? 32'b01 : 32'b10);
         prev_g = exp_d;
         tick();
      end
      inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
